// File: rtl/branch_predict_pc_if.sv
// Fetch/execute bundle of the branch-predicting PC unit.
// The slave modport is the PC unit itself; the master side drives stall and the execute resolution.
interface branch_predict_pc_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_npc;
    logic            ex_valid;
    logic [3:0]      ex_info_branch;
    logic [XLEN-1:0] ex_reg1;
    logic [XLEN-1:0] ex_reg2;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_pred_npc;
    logic            flush;

    modport master (
        output stall, ex_valid, ex_info_branch, ex_reg1, ex_reg2, ex_target, ex_pc, ex_pred_npc,
        input  pc, pred_taken, pred_npc, flush
    );

    modport slave (
        input  stall, ex_valid, ex_info_branch, ex_reg1, ex_reg2, ex_target, ex_pc, ex_pred_npc,
        output pc, pred_taken, pred_npc, flush
    );
endinterface

// File: rtl/branch_predict_pc.sv
// Fetch PC register with direct-mapped 2-bit-counter branch predictor and execute-stage redirect.
// Define BRANCH_PREDICT_EN to build the predictor table; otherwise fetch always predicts pc+4.
module branch_predict_pc #(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst_n,
    branch_predict_pc_if.slave bus
);
    // info_branch codes, matching the core's define file
    localparam logic [3:0] NOTBRANCH = 4'd0;
    localparam logic [3:0] Beq       = 4'd1;
    localparam logic [3:0] Bne       = 4'd2;
    localparam logic [3:0] Blt       = 4'd3;
    localparam logic [3:0] Bge       = 4'd4;
    localparam logic [3:0] Bltu      = 4'd5;
    localparam logic [3:0] Bgeu      = 4'd6;
    localparam logic [3:0] BJAL      = 4'd7;
    localparam logic [3:0] BJALR     = 4'd8;

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predict_pc: ENTRIES must be a power of two >= 2");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_npc;

    logic            eq, slt, ult;
    logic            is_br, taken;
    logic            resolve, mispredict;
    logic [XLEN-1:0] actual_npc;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Branch resolution
    assign eq  = bus.ex_reg1 == bus.ex_reg2;
    assign slt = $signed(bus.ex_reg1) < $signed(bus.ex_reg2);
    assign ult = bus.ex_reg1 < bus.ex_reg2;

    always_comb begin
        is_br = 1'b1;
        taken = 1'b0;
        case (bus.ex_info_branch)
            Beq:   taken = eq;
            Bne:   taken = !eq;
            Blt:   taken = slt;
            Bge:   taken = !slt;
            Bltu:  taken = ult;
            Bgeu:  taken = !ult;
            BJAL:  taken = 1'b1;
            BJALR: taken = 1'b1;
            NOTBRANCH: is_br = 1'b0;
            default:   is_br = 1'b0;
        endcase
    end

    assign actual_npc = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    assign resolve    = bus.ex_valid & is_br;
    assign mispredict = resolve & (actual_npc != bus.ex_pred_npc);

`ifdef BRANCH_PREDICT_EN
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [ENTRIES-1:0]                 tbl_valid;
    logic [ENTRIES-1:0][TAGW-1:0]       tbl_tag;
    logic [ENTRIES-1:0][XLEN-1:0]       tbl_tgt;
    logic [ENTRIES-1:0][1:0]            tbl_ctr;

    logic [IDX-1:0]  rd_idx, wr_idx;
    logic [TAGW-1:0] rd_tag, wr_tag;
    logic            rd_hit, wr_hit;

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_tag = pc_q[XLEN-1:IDX+2];
    assign wr_idx = bus.ex_pc[IDX+1:2];
    assign wr_tag = bus.ex_pc[XLEN-1:IDX+2];

    // Lookup reads the pre-edge table, so a same-cycle write to rd_idx is not seen
    assign rd_hit     = tbl_valid[rd_idx] && (tbl_tag[rd_idx] == rd_tag);
    assign wr_hit     = tbl_valid[wr_idx] && (tbl_tag[wr_idx] == wr_tag);
    assign pred_taken = rd_hit & tbl_ctr[rd_idx][1];
    assign pred_npc   = pred_taken ? tbl_tgt[rd_idx] : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid <= '0;
            tbl_tag   <= '0;
            tbl_tgt   <= '0;
            tbl_ctr   <= {ENTRIES{2'b01}};
        end else if (resolve) begin
            if (wr_hit) begin
                if (taken) begin
                    tbl_tgt[wr_idx] <= bus.ex_target;
                    if (tbl_ctr[wr_idx] != 2'b11) tbl_ctr[wr_idx] <= tbl_ctr[wr_idx] + 2'b01;
                end else if (tbl_ctr[wr_idx] != 2'b00) begin
                    tbl_ctr[wr_idx] <= tbl_ctr[wr_idx] - 2'b01;
                end
            end else if (taken) begin
                // Allocation evicts whatever aliased entry held this index
                tbl_valid[wr_idx] <= 1'b1;
                tbl_tag[wr_idx]   <= wr_tag;
                tbl_tgt[wr_idx]   <= bus.ex_target;
                tbl_ctr[wr_idx]   <= 2'b10;
            end
        end
    end
`else
    assign pred_taken = 1'b0;
    assign pred_npc   = pc_plus4;
`endif

    // Redirect outranks stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pc_q <= RESET_PC;
        else if (mispredict) pc_q <= actual_npc;
        else if (!bus.stall) pc_q <= pred_npc;
    end

    assign bus.pc         = pc_q;
    assign bus.pred_taken = pred_taken;
    assign bus.pred_npc   = pred_npc;
    assign bus.flush      = mispredict;
endmodule

// File: tb/tb_branch_predict_pc.sv
// Directed bench for branch_predict_pc: reset, stall, compare-code table, hysteresis, aliasing, async reset.
// Predictor expectations follow BRANCH_PREDICT_EN; without it every prediction must be pc+4.
module tb_branch_predict_pc;
    localparam logic [3:0] NOTBRANCH = 4'd0, Beq = 4'd1, Bne = 4'd2, Blt = 4'd3, Bge = 4'd4,
                           Bltu = 4'd5, Bgeu = 4'd6, BJAL = 4'd7, BJALR = 4'd8;
    localparam logic [31:0] R1 = 32'hFFAB_CD5A, R2 = 32'h123A_BDEA;

    logic clk, rst_n;
    int   tests = 0, fails = 0;

    branch_predict_pc_if #(.XLEN(32)) bus ();
    branch_predict_pc #(.XLEN(32), .ENTRIES(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] pnpc;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // en_* are the expectations with the predictor built; otherwise fetch must predict pc+4
    task automatic check_pred(input string name, input logic en_taken, input logic [31:0] en_npc,
                              input logic [31:0] cur_pc);
        check({name, " pc"}, bus.pc, cur_pc);
`ifdef BRANCH_PREDICT_EN
        check({name, " pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, en_taken});
        check({name, " pred_npc"}, bus.pred_npc, en_npc);
`else
        check({name, " pred_taken"}, {31'd0, bus.pred_taken}, 32'd0);
        check({name, " pred_npc"}, bus.pred_npc, cur_pc + 32'd4);
`endif
    endtask

    // One-cycle resolution; stall is held by the caller so the next pc is known
    task automatic resolve(input string name, input logic [3:0] code, input logic [31:0] expc,
                           input logic [31:0] tgt, input logic [31:0] pnpc,
                           input logic exp_flush, input logic [31:0] exp_pc);
        bus.ex_valid       = 1'b1;
        bus.ex_info_branch = code;
        bus.ex_pc          = expc;
        bus.ex_target      = tgt;
        bus.ex_pred_npc    = pnpc;
        #1;
        check({name, " flush"}, {31'd0, bus.flush}, {31'd0, exp_flush});
        tick();
        bus.ex_valid = 1'b0;
        check({name, " next pc"}, bus.pc, exp_pc);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{Beq,       32'h20C, 1'b0, 32'h0};
        vecs[1]  = '{Bne,       32'h20C, 1'b1, 32'h400};
        vecs[2]  = '{Blt,       32'h20C, 1'b1, 32'h400};
        vecs[3]  = '{Bge,       32'h20C, 1'b0, 32'h0};
        vecs[4]  = '{Bltu,      32'h20C, 1'b0, 32'h0};
        vecs[5]  = '{Bgeu,      32'h20C, 1'b1, 32'h400};
        vecs[6]  = '{BJAL,      32'h20C, 1'b1, 32'h400};
        vecs[7]  = '{BJALR,     32'h20C, 1'b1, 32'h400};
        vecs[8]  = '{NOTBRANCH, 32'h999, 1'b0, 32'h0};
        vecs[9]  = '{4'hF,      32'h999, 1'b0, 32'h0};
        vecs[10] = '{Bne,       32'h400, 1'b0, 32'h0};
        vecs[11] = '{Blt,       32'h404, 1'b1, 32'h400};
        vecs[12] = '{Beq,       32'h400, 1'b1, 32'h20C};

        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_info_branch = NOTBRANCH;
        bus.ex_reg1 = R1;
        bus.ex_reg2 = R2;
        bus.ex_target = '0;
        bus.ex_pc = '0;
        bus.ex_pred_npc = '0;
        #3;
        check_pred("reset", 1'b0, 32'h4, 32'h0);
        check("reset flush", {31'd0, bus.flush}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset pc", bus.pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_pred("free-run", 1'b0, 32'(i * 4 + 4), 32'(i * 4));
            check("free-run flush", {31'd0, bus.flush}, 32'd0);
        end

        bus.stall = 1'b1;
        tick(); check("stall 1", bus.pc, 32'h10);
        tick(); check("stall 2", bus.pc, 32'h10);
        bus.stall = 1'b0;
        tick(); check("stall release", bus.pc, 32'h14);

        resolve("bne alloc", Bne, 32'h100, 32'h200, 32'h104, 1'b1, 32'h200);

        // Compare-code table at ex_pc 0x208, target 0x400; pc free-runs between vectors
        bus.ex_pc = 32'h208;
        bus.ex_target = 32'h400;
        foreach (vecs[i]) begin
            bus.ex_valid = 1'b1;
            bus.ex_info_branch = vecs[i].code;
            bus.ex_pred_npc = vecs[i].pnpc;
            #1;
            check($sformatf("code[%0d] flush", i), {31'd0, bus.flush}, {31'd0, vecs[i].exp_flush});
            tick();
            bus.ex_valid = 1'b0;
            if (vecs[i].exp_flush) check($sformatf("code[%0d] redirect", i), bus.pc, vecs[i].exp_pc);
        end

        // Mispredict while stalled must still load the pc
        bus.stall = 1'b1;
        resolve("jal under stall", BJAL, 32'h50, 32'h100, 32'h54, 1'b1, 32'h100);
        check_pred("lookup 0x100", 1'b1, 32'h200, 32'h100);

        bus.ex_valid = 1'b1;
        bus.ex_info_branch = Beq;
        bus.ex_pc = 32'h100;
        bus.ex_pred_npc = 32'h104;
        #1;
        check_pred("same-cycle old", 1'b1, 32'h200, 32'h100);
        tick();
        bus.ex_valid = 1'b0;
        check_pred("ctr 01", 1'b0, 32'h104, 32'h100);

        resolve("taken 1", Bne, 32'h100, 32'h200, 32'h200, 1'b0, 32'h100);
        check_pred("ctr 10", 1'b1, 32'h200, 32'h100);
        resolve("taken 2", Bne, 32'h100, 32'h200, 32'h200, 1'b0, 32'h100);
        check_pred("ctr 11", 1'b1, 32'h200, 32'h100);
        resolve("taken new tgt", Bne, 32'h100, 32'h240, 32'h240, 1'b0, 32'h100);
        check_pred("tgt update", 1'b1, 32'h240, 32'h100);
        resolve("nt 1", Beq, 32'h100, 32'h240, 32'h104, 1'b0, 32'h100);
        check_pred("sat ctr 10", 1'b1, 32'h240, 32'h100);
        resolve("nt 2", Beq, 32'h100, 32'h240, 32'h104, 1'b0, 32'h100);
        check_pred("ctr back 01", 1'b0, 32'h104, 32'h100);

        // 0x140 shares index 0 with 0x100 but not its tag
        resolve("to alias", BJAL, 32'h60, 32'h140, 32'h64, 1'b1, 32'h140);
        check_pred("alias miss", 1'b0, 32'h144, 32'h140);
        resolve("alias alloc", Bne, 32'h140, 32'h300, 32'h300, 1'b0, 32'h140);
        check_pred("alias hit", 1'b1, 32'h300, 32'h140);
        resolve("back to 0x100", BJAL, 32'h60, 32'h100, 32'h64, 1'b1, 32'h100);
        check_pred("evicted", 1'b0, 32'h104, 32'h100);

        resolve("bne again 1", Bne, 32'h100, 32'h200, 32'h104, 1'b1, 32'h200);
        resolve("bne again 2", Bne, 32'h100, 32'h200, 32'h104, 1'b1, 32'h200);

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset pc", bus.pc, 32'h0);
        check("async reset npc", bus.pred_npc, 32'h4);
        #2;
        rst_n = 1'b1;
        resolve("after reset", BJAL, 32'h60, 32'h140, 32'h64, 1'b1, 32'h140);
        check_pred("valid cleared", 1'b0, 32'h144, 32'h140);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
